ram_req_ctrl: RTL and testbench
===============================

RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

Interface
REQ-001 SHALL have parameter RD_TIMEOUT, default 15, max cycles to wait for read_ready before an error response.
REQ-002 SHALL have port clk  input  1  single clock; all sequential logic on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid/req_ready  input/output  1/1  CPU request handshake; transfer when both high at posedge.
REQ-005 SHALL have port req_we  input  1  1=write, 0=read.
REQ-006 SHALL have ports req_addr (input, 23, byte address) and req_be (input, 4, byte enables for writes).
REQ-007 SHALL have port req_wdata  input  32  write data.
REQ-008 SHALL have ports rsp_valid (output, 1, one-cycle pulse), rsp_rdata (output, 32) and rsp_err (output, 1).
REQ-009 SHALL have driver-side ports ram_enable, ram_enable_read, ram_enable_write (outputs, 1 each), ram_addr (output, 21), ram_data_in (output, 32), ram_data_out (input, 32), ram_write_finished (input, 1) and ram_read_ready (input, 1).

Function
REQ-010 SHALL use states IDLE, RD, RD_REL, WR_ISSUE, WR_WAIT, RMW_RD, RMW_REL.
REQ-011 SHALL drive req_ready high only in IDLE; all request fields latched on acceptance.
REQ-012 SHALL drive ram_addr = latched req_addr[22:2]; req_addr[1:0] != 0 -> no RAM access, rsp_valid+rsp_err the cycle after acceptance.
REQ-013 SHALL hold ram_enable high in every state except IDLE.
REQ-014 Read: IDLE->RD, ram_enable_read held high until ram_read_ready sampled high; that edge captures ram_data_out into rsp_rdata and moves to RD_REL.
REQ-015 SHALL hold ram_enable_read low in RD_REL for exactly one cycle with rsp_valid=1, then return to IDLE, so the driver returns to its idle state before any new command.
REQ-016 Write, req_be=4'hF: IDLE->WR_ISSUE (ram_enable_write high exactly one cycle) -> WR_WAIT until ram_write_finished sampled high -> IDLE.
REQ-017 SHALL pulse rsp_valid with rsp_err=0 in the cycle after ram_write_finished is sampled.
REQ-018 SHALL never assert ram_enable_read and ram_enable_write together.
REQ-019 Write with req_be=4'h0 SHALL complete with rsp_valid, rsp_err=0 and no RAM access.
REQ-020 In RD/RMW_RD, RD_TIMEOUT cycles without ram_read_ready SHALL drop ram_enable_read, pulse rsp_valid+rsp_err and return to IDLE.
REQ-021 req_valid while busy SHALL be ignored (held off by req_ready=0); the requester keeps it stable.

Reset
REQ-022 While rst_n=0: state=IDLE; req_ready=1 after release; rsp_valid, rsp_err, all ram_enable* =0; rsp_rdata=0; ram_addr=0; ram_data_in=0.
REQ-023 Reset mid-transaction SHALL abort it immediately with no response; ram_enable dropping returns the driver to idle.

Configuration
REQ-024 With RAM_RMW_EN defined, a write with partial req_be SHALL run RMW_RD (read as REQ-014) -> RMW_REL -> merge bytes where req_be=1 -> WR_ISSUE -> WR_WAIT.
REQ-025 Without RAM_RMW_EN, req_be SHALL be ignored except 4'h0, and any nonzero mask SHALL write the full word.

Structure
REQ-026 SHALL place state encoding localparams and the 23-bit address width constant in shared package memtrans_pkg.
REQ-027 SHALL place the byte-merge logic in sub-module ram_byte_merge (old word, new word, be -> merged word).

Verification
REQ-028 Read 0x000010 with driver model -> rsp_valid 7 edges after acceptance, rsp_rdata = model word 4, ram_enable_read low in RD_REL.
REQ-029 Full write 0x400008 data 0xDEADBEEF -> single ram_enable_write pulse, ram_addr=0x100002, rsp_valid after write_finished, readback matches.
REQ-030 RAM_RMW_EN: word 0x11223344, write be=4'b0010 data 0x0000AA00 -> readback 0x1122AA44.
REQ-031 Misaligned read 0x000003 -> rsp_err=1 next cycle, ram_enable never high.
REQ-032 Driver model never raises read_ready -> rsp_err after RD_TIMEOUT=15 cycles, controller back in IDLE.
REQ-033 rst_n low during WR_WAIT -> all outputs at reset values asynchronously, no rsp_valid, next read succeeds.

Source files
------------

// File: rtl/memtrans_pkg.sv
// Shared widths and FSM state encoding for the RAM request controller.
package memtrans_pkg;

    localparam int unsigned ADDR_W     = 23;
    localparam int unsigned RAM_ADDR_W = ADDR_W - 2;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BE_W       = DATA_W / 8;
    localparam int unsigned STATE_W    = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t RD       = 3'd1;
    localparam state_t RD_REL   = 3'd2;
    localparam state_t WR_ISSUE = 3'd3;
    localparam state_t WR_WAIT  = 3'd4;
    localparam state_t RMW_RD   = 3'd5;
    localparam state_t RMW_REL  = 3'd6;

endpackage

// File: rtl/ram_byte_merge.sv
// Byte-lane merge: lanes with be=1 take the new word, the rest keep the old word.
module ram_byte_merge
    import memtrans_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] merged_c
);

    always_comb begin
        merged_c = old_word;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (be[b]) merged_c[8*b +: 8] = new_word[8*b +: 8];
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// CPU request to RAM driver command controller with read timeout.
// Optional read-modify-write of partial byte enables via `define RAM_RMW_EN.
module ram_req_ctrl
    import memtrans_pkg::*;
#(
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [BE_W-1:0]       req_be,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_enable,
    output logic                  ram_enable_read,
    output logic                  ram_enable_write,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_data_in,
    input  logic [DATA_W-1:0]     ram_data_out,
    input  logic                  ram_write_finished,
    input  logic                  ram_read_ready
);

    localparam int unsigned TMO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

    state_t           state;
    state_t           next_state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             accept_c;
    logic             misalign_c;
    logic             in_rd_c;
    logic             rd_tmo_c;
    logic             req_ready_d;
    logic             ram_enable_d;
    logic             ram_enable_read_d;
    logic             ram_enable_write_d;
    logic             rsp_valid_d;
    logic             rsp_err_d;

    assign accept_c   = req_valid & req_ready;
    assign misalign_c = |req_addr[1:0];
    assign in_rd_c    = (state == RD) || (state == RMW_RD);
    assign rd_tmo_c   = in_rd_c && !ram_read_ready && (tmo_cnt == TMO_LAST);

`ifdef RAM_RMW_EN
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] merged_c;

    ram_byte_merge u_merge (
        .old_word (ram_data_out),
        .new_word (ram_data_in),
        .be       (be_q),
        .merged_c (merged_c)
    );
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_c && !misalign_c) begin
                    if (!req_we) begin
                        next_state = RD;
                    end else if (req_be != '0) begin
`ifdef RAM_RMW_EN
                        next_state = (req_be == '1) ? WR_ISSUE : RMW_RD;
`else
                        next_state = WR_ISSUE;
`endif
                    end
                end
            end
            RD: begin
                if (ram_read_ready) next_state = RD_REL;
                else if (rd_tmo_c)  next_state = IDLE;
            end
            RD_REL:   next_state = IDLE;
            RMW_RD: begin
                if (ram_read_ready) next_state = RMW_REL;
                else if (rd_tmo_c)  next_state = IDLE;
            end
            RMW_REL:  next_state = WR_ISSUE;
            WR_ISSUE: next_state = WR_WAIT;
            WR_WAIT: begin
                if (ram_write_finished) next_state = IDLE;
            end
            default:  next_state = IDLE;
        endcase
    end

    // Output logic: values the output registers take at the next edge
    always_comb begin
        req_ready_d        = (next_state == IDLE);
        ram_enable_d       = (next_state != IDLE);
        ram_enable_read_d  = (next_state == RD) || (next_state == RMW_RD);
        ram_enable_write_d = (next_state == WR_ISSUE);
        rsp_valid_d        = 1'b0;
        rsp_err_d          = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c && (misalign_c || (req_we && (req_be == '0)))) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = misalign_c;
                end
            end
            RD: begin
                if (ram_read_ready) begin
                    rsp_valid_d = 1'b1;
                end else if (rd_tmo_c) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            RMW_RD: begin
                if (rd_tmo_c) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            WR_WAIT: begin
                if (ram_write_finished) rsp_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output and request datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready        <= 1'b1;
            ram_enable       <= 1'b0;
            ram_enable_read  <= 1'b0;
            ram_enable_write <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_err          <= 1'b0;
            rsp_rdata        <= '0;
            ram_addr         <= '0;
            ram_data_in      <= '0;
            tmo_cnt          <= '0;
`ifdef RAM_RMW_EN
            be_q             <= '0;
`endif
        end else begin
            req_ready        <= req_ready_d;
            ram_enable       <= ram_enable_d;
            ram_enable_read  <= ram_enable_read_d;
            ram_enable_write <= ram_enable_write_d;
            rsp_valid        <= rsp_valid_d;
            rsp_err          <= rsp_err_d;
            if (accept_c) begin
                ram_addr    <= req_addr[ADDR_W-1:2];
                ram_data_in <= req_wdata;
                tmo_cnt     <= '0;
`ifdef RAM_RMW_EN
                be_q        <= req_be;
`endif
            end else if (in_rd_c) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
                if (ram_read_ready) begin
                    if (state == RD) rsp_rdata <= ram_data_out;
`ifdef RAM_RMW_EN
                    else             ram_data_in <= merged_c;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Randomized bench for ram_req_ctrl with a RAM driver model and a word-level reference memory.
module tb_ram_req_ctrl;
    import memtrans_pkg::*;

    localparam int unsigned RD_TIMEOUT = 15;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  req_we = 1'b0;
    logic [ADDR_W-1:0]     req_addr = '0;
    logic [BE_W-1:0]       req_be = '0;
    logic [DATA_W-1:0]     req_wdata = '0;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  ram_enable;
    logic                  ram_enable_read;
    logic                  ram_enable_write;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_data_in;
    logic [DATA_W-1:0]     ram_data_out = '0;
    logic                  ram_write_finished = 1'b0;
    logic                  ram_read_ready = 1'b0;

    ram_req_ctrl #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_we             (req_we),
        .req_addr           (req_addr),
        .req_be             (req_be),
        .req_wdata          (req_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .rsp_err            (rsp_err),
        .ram_enable         (ram_enable),
        .ram_enable_read    (ram_enable_read),
        .ram_enable_write   (ram_enable_write),
        .ram_addr           (ram_addr),
        .ram_data_in        (ram_data_in),
        .ram_data_out       (ram_data_out),
        .ram_write_finished (ram_write_finished),
        .ram_read_ready     (ram_read_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Initial RAM content: every word is tagged with its own address
    function automatic logic [31:0] init_word(input int idx);
        return 32'hC000_0000 | (32'(idx) & 32'h001F_FFFF);
    endfunction

    // ---------------- RAM driver model ----------------
    int               rd_lat = 5;
    int               wr_lat = 2;
    bit               no_ready = 1'b0;
    int               rd_cnt = 0;
    int               wr_cnt = 0;
    bit               wr_pend = 1'b0;
    logic [31:0]      drv_mem [int];
    logic [20:0]      last_wr_addr = '0;

    function automatic logic [31:0] drv_word(input int idx);
        return drv_mem.exists(idx) ? drv_mem[idx] : init_word(idx);
    endfunction

    always @(posedge clk) begin
        if (!ram_enable) begin
            rd_cnt             <= 0;
            ram_read_ready     <= 1'b0;
            wr_cnt             <= 0;
            wr_pend            <= 1'b0;
            ram_write_finished <= 1'b0;
        end else begin
            if (ram_enable_read && !no_ready) begin
                if (rd_cnt == rd_lat) begin
                    ram_read_ready <= 1'b1;
                    ram_data_out   <= drv_word(int'(ram_addr));
                end else begin
                    rd_cnt <= rd_cnt + 1;
                end
            end else begin
                rd_cnt         <= 0;
                ram_read_ready <= 1'b0;
            end
            ram_write_finished <= 1'b0;
            if (ram_enable_write) begin
                drv_mem[int'(ram_addr)] = ram_data_in;
                last_wr_addr <= ram_addr;
                wr_cnt       <= wr_lat;
                wr_pend      <= 1'b1;
            end else if (wr_pend) begin
                if (wr_cnt == 0) begin
                    ram_write_finished <= 1'b1;
                    wr_pend            <= 1'b0;
                end else begin
                    wr_cnt <= wr_cnt - 1;
                end
            end
        end
    end

    // Per-cycle activity counters, sampled just after each edge
    int en_cyc = 0;
    int wrp = 0;
    int ovl = 0;
    always @(posedge clk) begin
        #1;
        if (ram_enable)                        en_cyc++;
        if (ram_enable_write)                  wrp++;
        if (ram_enable_read && ram_enable_write) ovl++;
    end

    // ---------------- Reference memory ----------------
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_word(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
    endfunction

    function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // ---------------- Request driver ----------------
    int          got_lat;
    logic [31:0] got_rdata;
    logic        got_err;
    logic        got_en;
    logic        got_en_rd;
    int          en0, wr0, ov0;

    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr, input logic [BE_W-1:0] be,
                          input logic [DATA_W-1:0] wd);
        int w;
        bit seen;
        @(negedge clk);
        req_we = we; req_addr = addr; req_be = be; req_wdata = wd; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 64'(req_ready), 64'(1));
            req_valid = 1'b0;
            got_lat = -1;
            return;
        end
        en0 = en_cyc; wr0 = wrp; ov0 = ovl;
        @(posedge clk);
        got_lat = 0;
        seen = 1'b0;
        while (!seen && got_lat < 200) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) begin
                seen      = 1'b1;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
                got_en    = ram_enable;
                got_en_rd = ram_enable_read;
            end else begin
                got_lat++;
            end
        end
        if (!seen) begin
            chk("rsp_timeout", 64'(seen), 64'(1));
            return;
        end
        @(negedge clk);
        chk("rsp_pulse", 64'(rsp_valid), 64'(0));
    endtask

    // Predict, issue, and compare one transaction
    task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [BE_W-1:0] be,
                           input logic [DATA_W-1:0] wd);
        int          idx;
        int          exp_lat;
        int          exp_wr;
        logic        exp_err;
        logic        exp_en;
        bit          access;
        logic [31:0] exp_rd;
        idx = int'(addr[ADDR_W-1:2]);
        exp_lat = 0; exp_wr = 0; exp_err = 1'b0; exp_en = 1'b0; access = 1'b1; exp_rd = '0;
        if (addr[1:0] != 2'b00) begin
            exp_err = 1'b1;
            access  = 1'b0;
        end else if (!we) begin
            if (no_ready) begin
                exp_err = 1'b1;
                exp_lat = RD_TIMEOUT;
            end else begin
                exp_lat = rd_lat + 2;
                exp_rd  = ref_word(idx);
                exp_en  = 1'b1;
            end
        end else if (be == 4'h0) begin
            access = 1'b0;
        end
`ifdef RAM_RMW_EN
        else if (be != 4'hF) begin
            if (no_ready) begin
                exp_err = 1'b1;
                exp_lat = RD_TIMEOUT;
            end else begin
                ref_mem[idx] = merge_ref(ref_word(idx), wd, be);
                exp_lat = rd_lat + wr_lat + 6;
                exp_wr  = 1;
            end
        end
`endif
        else begin
            ref_mem[idx] = wd;
            exp_lat = wr_lat + 3;
            exp_wr  = 1;
        end
        do_req(we, addr, be, wd);
        chk("rsp_latency", 64'(got_lat), 64'(exp_lat));
        chk("rsp_err", 64'(got_err), 64'(exp_err));
        chk("enable_at_rsp", 64'(got_en), 64'(exp_en));
        chk("enable_read_at_rsp", 64'(got_en_rd), 64'(0));
        if (exp_en) chk("rsp_rdata", 64'(got_rdata), 64'(exp_rd));
        chk("write_pulses", 64'(wrp - wr0), 64'(exp_wr));
        chk("rd_wr_overlap", 64'(ovl - ov0), 64'(0));
        if (!access) chk("no_ram_access", 64'(en_cyc - en0), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rsp;
        logic [ADDR_W-1:0] a;
        logic [BE_W-1:0]   be;
        logic [1:0]        lo;
        int                r;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ram_enable", 64'(ram_enable), 64'(0));
        chk("rst_enable_rw", 64'({ram_enable_read, ram_enable_write}), 64'(0));
        chk("rst_rsp", 64'({rsp_valid, rsp_err}), 64'(0));
        chk("rst_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_ram_addr", 64'(ram_addr), 64'(0));
        chk("rst_data_in", 64'(ram_data_in), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(1));

        // Aligned read with 5-cycle driver latency
        rd_lat = 5; wr_lat = 2;
        run_txn(1'b0, 23'h000010, 4'h0, 32'h0);
        chk("read_lat_7", 64'(got_lat), 64'(7));
        chk("read_word4", 64'(got_rdata), 64'(32'hC000_0004));

        // Full write and readback
        run_txn(1'b1, 23'h400008, 4'hF, 32'hDEAD_BEEF);
        chk("write_ram_addr", 64'(last_wr_addr), 64'(21'h100002));
        run_txn(1'b0, 23'h400008, 4'h0, 32'h0);
        chk("write_readback", 64'(got_rdata), 64'(32'hDEAD_BEEF));

        // Partial write
        run_txn(1'b1, 23'h000100, 4'hF, 32'h1122_3344);
        run_txn(1'b1, 23'h000100, 4'b0010, 32'h0000_AA00);
        run_txn(1'b0, 23'h000100, 4'h0, 32'h0);
`ifdef RAM_RMW_EN
        chk("partial_readback", 64'(got_rdata), 64'(32'h1122_AA44));
`else
        chk("partial_readback", 64'(got_rdata), 64'(32'h0000_AA00));
`endif

        // Misaligned read and empty-mask write
        run_txn(1'b0, 23'h000003, 4'h0, 32'h0);
        chk("misalign_err", 64'(got_err), 64'(1));
        run_txn(1'b1, 23'h000020, 4'h0, 32'h1234_5678);

        // Read timeout
        no_ready = 1'b1;
        run_txn(1'b0, 23'h000020, 4'h0, 32'h0);
        chk("timeout_lat", 64'(got_lat), 64'(RD_TIMEOUT));
        chk("timeout_idle_ready", 64'(req_ready), 64'(1));
        no_ready = 1'b0;

        // Reset while waiting for write completion
        @(negedge clk);
        chk("pre_abort_ready", 64'(req_ready), 64'(1));
        wr_lat = 20;
        req_we = 1'b1; req_addr = 23'h200000; req_be = 4'hF; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_enable", 64'({ram_enable, ram_enable_read, ram_enable_write}), 64'(0));
        chk("abort_rsp", 64'({rsp_valid, rsp_err}), 64'(0));
        chk("abort_ready", 64'(req_ready), 64'(1));
        chk("abort_addr_data", 64'({ram_addr, ram_data_in}), 64'(0));
        chk("abort_rdata", 64'(rsp_rdata), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr_lat = 2;
        n_rsp = 0;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        chk("abort_no_rsp", 64'(n_rsp), 64'(0));
        run_txn(1'b0, 23'h000010, 4'h0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            rd_lat   = $urandom_range(0, 6);
            wr_lat   = $urandom_range(0, 4);
            no_ready = ($urandom_range(0, 15) == 0);
            lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            a  = {21'($urandom_range(0, 31)), lo};
            r  = $urandom_range(0, 3);
            be = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom_range(1, 14));
            run_txn(1'($urandom_range(0, 1)), a, be, 32'($urandom));
        end
        no_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
